// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/half/word access, sign/zero extension and a fixed wait-state latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned or reserved-size accesses instead of ignoring low address bits.
module data_memory_sized #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, commit, fault;

  logic        lat_we, lat_uns;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        cur_we, cur_uns;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  lo;
  logic [AW-1:0] idx;
  logic [31-AW-2:0] unused_hi;

  logic [3:0]  mask;
  logic [31:0] wsh, rword, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [31:0] mem [DEPTH] = '{default: '0};

  assign accept = req && !reset && (state == S_IDLE || state == S_RESP);

  // With no wait states the access completes on its accepting edge, so it acts on the live inputs.
  assign commit = !reset && ((WAIT_STATES == 0) ? accept : (state == S_WAIT && cnt == 4'd1));

  assign cur_we    = (WAIT_STATES == 0) ? we          : lat_we;
  assign cur_uns   = (WAIT_STATES == 0) ? unsigned_ld : lat_uns;
  assign cur_size  = (WAIT_STATES == 0) ? size        : lat_size;
  assign cur_addr  = (WAIT_STATES == 0) ? address     : lat_addr;
  assign cur_wdata = (WAIT_STATES == 0) ? write_data  : lat_wdata;

  assign lo        = cur_addr[1:0];
  assign idx       = cur_addr[AW+1:2];
  assign unused_hi = cur_addr[31:AW+2];
  assign rword     = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = (cur_size == 2'b11) ||
                 (cur_size == 2'b01 && lo[0]) ||
                 (cur_size == 2'b10 && lo != 2'b00);
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(WAIT_STATES);
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RESP: state_nxt = accept ? ((WAIT_STATES == 0) ? S_RESP : S_WAIT) : S_IDLE;
      S_WAIT:         if (cnt == 4'd1) state_nxt = S_RESP;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= we;
      lat_uns   <= unsigned_ld;
      lat_size  <= size;
      lat_addr  <= address;
      lat_wdata <= write_data;
    end
  end

  // Reserved size falls into the word branch; in the trapping build it never commits anyway.
  always_comb begin
    mask    = 4'b1111;
    wsh     = cur_wdata;
    ld_byte = rword[7:0];
    ld_half = lo[1] ? rword[31:16] : rword[15:0];
    case (lo)
      2'b00:   ld_byte = rword[7:0];
      2'b01:   ld_byte = rword[15:8];
      2'b10:   ld_byte = rword[23:16];
      default: ld_byte = rword[31:24];
    endcase
    case (cur_size)
      2'b00: begin
        mask   = 4'b0001 << lo;
        wsh    = {4{cur_wdata[7:0]}};
        ld_val = cur_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        mask   = lo[1] ? 4'b1100 : 4'b0011;
        wsh    = {2{cur_wdata[15:0]}};
        ld_val = cur_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: ld_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && cur_we && !fault) begin
      for (int unsigned b = 0; b < 4; b++)
        if (mask[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      read_data <= '0;
    else if (commit && (!cur_we || fault))
      read_data <= fault ? '0 : ld_val;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (commit)
      err_q <= fault;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: one-wait-state/1024-word and zero-wait-state/16-word instances
// checked against a byte-addressed reference memory.
module tb_data_memory_sized;

  localparam int unsigned DEP0 = 1024, WS0 = 1;
  localparam int unsigned DEP1 = 16,   WS1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2], req [2], we [2], uns [2], rdy [2], err [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2], wd [2], rd [2];

  data_memory_sized #(.DEPTH(DEP0), .WAIT_STATES(WS0)) dut (
    .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
    .unsigned_ld(uns[0]), .address(addr[0]), .write_data(wd[0]),
    .ready(rdy[0]), .read_data(rd[0]), .err(err[0]));

  data_memory_sized #(.DEPTH(DEP1), .WAIT_STATES(WS1)) dut0 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
    .unsigned_ld(uns[1]), .address(addr[1]), .write_data(wd[1]),
    .ready(rdy[1]), .read_data(rd[1]), .err(err[1]));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    int unsigned due;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        q [$];
  exp_t        mon_x;
  int          n_pass = 0, n_tot = 0;
  logic [7:0]  bmem [2][4096];
  logic [31:0] last_rd [2];

  function automatic int unsigned depth_of(input int i);
    return (i == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int unsigned ws_of(input int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: memory as a flat little-endian byte array; address reduced modulo its byte size.
  task automatic model(input int i, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] r);
    int unsigned nb, base;
    logic [31:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    e = (sz == 2'b11) || ((a % nb) != 0);
`else
    e = 1'b0;
`endif
    if (e) begin
      last_rd[i] = '0;
      r = '0;
      return;
    end
    base = (a - (a % nb)) % (depth_of(i) * 4);
    if (w) begin
      for (int k = 0; k < int'(nb); k++) bmem[i][base + k] = d[8*k +: 8];
      r = last_rd[i];
    end else begin
      v = '0;
      for (int k = 0; k < int'(nb); k++) v = v | (32'(bmem[i][base + k]) << (8 * k));
      if (!u && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!u && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      last_rd[i] = v;
      r = v;
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input int gap);
    exp_t x;
    repeat (gap) begin
      @(negedge clk);
      req[i] = 1'b0;
    end
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; size[i] = sz; uns[i] = u; addr[i] = a; wd[i] = d;
    @(posedge clk);
    #1;
    x.inst = i;
    x.due  = cyc + ws_of(i);
    model(i, w, sz, u, a, d, x.err, x.rd);
    q.push_back(x);
    // Junk requests while waiting must be ignored.
    repeat (ws_of(i)) begin
      @(negedge clk);
      req[i] = 1'($urandom_range(0, 1)); we[i] = 1'($urandom_range(0, 1));
      size[i] = 2'($urandom_range(0, 3)); addr[i] = $urandom; wd[i] = $urandom;
    end
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      req[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] === 1'b1) begin
        if (q.size() == 0 || q[0].inst != i) begin
          n_tot++;
          $display("FAIL unexpected_ready inst%0d: got ready=1 expected ready=0 (cycle %0d)", i, cyc);
        end else begin
          mon_x = q.pop_front();
          check("ready_cycle", cyc, mon_x.due);
          check("read_data", rd[i], mon_x.rd);
          check("err", 32'(err[i]), 32'(mon_x.err));
        end
      end else if (q.size() > 0 && q[0].inst == i && cyc > q[0].due) begin
        mon_x = q.pop_front();
        n_tot++;
        $display("FAIL missing_ready inst%0d: got ready=0 expected ready=1 at cycle %0d", i, mon_x.due);
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4096; b++) bmem[i][b] = '0;
      last_rd[i] = '0;
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; uns[i] = 1'b0;
      size[i] = 2'b10; addr[i] = '0; wd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(rdy[i]), 32'h0);
      check("reset_err", 32'(err[i]), 32'h0);
      check("reset_read_data", rd[i], 32'h0);
      rst[i] = 1'b0;
    end

    issue(0, 1'b1, 2'b10, 1'b0, 32'h10,   32'hDEAD_BEEF, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0, 1);
    issue(0, 1'b1, 2'b00, 1'b0, 32'h13,   32'h80, 0);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h13,   32'h0, 0);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h13,   32'h0, 2);
    issue(0, 1'b0, 2'b10, 1'b1, 32'h10,   32'h0, 0);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h22,   32'h1234, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 0);
    issue(0, 1'b0, 2'b01, 1'b0, 32'h22,   32'h0, 0);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0, 0);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h11,   32'h0, 1);

    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 63) | ($urandom_range(0, 3) << 12) | ($urandom_range(0, 1) << 31);
      issue(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, $urandom_range(0, 2));
    end
    idle(0, 4);

    // Store accepted then reset on the next edge: no response, no commit; a request during reset is ignored.
    issue(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_A5A5, 1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h40; wd[0] = 32'h1111_1111;
    @(negedge clk);
    rst[0] = 1'b1; wd[0] = 32'h2222_2222;
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b0;
    last_rd[0] = '0;
    check("abort_ready", 32'(rdy[0]), 32'h0);
    check("abort_read_data", rd[0], 32'h0);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2);
    idle(0, 4);

    for (int n = 0; n < 150; n++) begin
      issue(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 255), $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    idle(1, 4);

    check("queue_drained", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
